// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI master controller.
// State encoding, SPI mode constants ({CPOL, CPHA}) and the edge-counter width helper.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } spi_state_t;

   // Each mode encodes {CPOL, CPHA}.
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   // The edge counter must hold the value 2*bits (the last sclk edge).
   function automatic int edge_cnt_width(input int bits);
      return $clog2(2 * bits + 1);
   endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: requester-side handshake of the SPI master.
// The requester uses the master modport; the controller uses the slave modport.
interface spi_master_ctrl_if #(parameter int BITS = 12) ();
   logic            start;
   logic [BITS-1:0] din;
   logic            busy;
   logic            done;
   logic [BITS-1:0] dout;

   modport master (output start, output din, input busy, input done, input dout);
   modport slave  (input start, input din, output busy, output done, output dout);
endinterface

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick generator. Emits a one-cycle tick every
// CLK_DIV enabled cycles; the count restarts from zero whenever en is low.
module spi_clk_div #(
   parameter int CLK_DIV = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   // Count enabled cycles modulo CLK_DIV; cleared while disabled so it restarts on enable rise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!en) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = en && (cnt == LAST);
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: full-duplex SPI master with configurable width, divider,
// CPOL/CPHA and bit order. sclk is a registered data output, never a clock.
// Optional feature macro: SPI_MASTER_LOOPBACK_EN (adds the loopback input,
// which routes the internal mosi register into the RX sampler).
module spi_master_ctrl import spi_pkg::*; #(
   parameter int BITS      = 12,
   parameter int CLK_DIV   = 5,
   parameter bit CPOL      = 1'b0,
   parameter bit CPHA      = 1'b0,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   spi_master_ctrl_if.slave  bus,
   input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic              loopback,
`endif
   output logic              sclk,
   output logic              mosi,
   output logic              cs_n
);
   localparam int            EW        = edge_cnt_width(BITS);
   localparam logic [EW-1:0] LAST_EDGE = EW'(2 * BITS);
   localparam logic [EW-1:0] PENULT    = EW'(2 * BITS - 1);
   localparam logic [1:0]    S_IDLE    = IDLE;
   localparam logic [1:0]    S_SETUP   = SETUP;
   localparam logic [1:0]    S_XFER    = XFER;
   localparam logic [1:0]    S_HOLD    = HOLD;

   logic [1:0]      state;
   logic [BITS-1:0] tx_sr;
   logic [BITS-1:0] rx_sr;
   logic [EW-1:0]   edge_cnt;
   logic            tick;
   logic            lead;
   logic            do_edge;
   logic            rx_bit;

   function automatic logic first_bit(input logic [BITS-1:0] w);
      return MSB_FIRST ? w[BITS-1] : w[0];
   endfunction

   function automatic logic [BITS-1:0] shift_out(input logic [BITS-1:0] w);
      return MSB_FIRST ? {w[BITS-2:0], 1'b0} : {1'b0, w[BITS-1:1]};
   endfunction

   // Received bits enter at the end opposite to the first bit so the word lands in natural order.
   function automatic logic [BITS-1:0] shift_in(input logic [BITS-1:0] w, input logic b);
      return MSB_FIRST ? {w[BITS-2:0], b} : {b, w[BITS-1:1]};
   endfunction

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .clk  (clk),
      .rst  (rst),
      .en   (state != S_IDLE),
      .tick (tick)
   );

`ifdef SPI_MASTER_LOOPBACK_EN
   logic lb;
   assign rx_bit = lb ? mosi : miso;
`else
   assign rx_bit = miso;
`endif

   // The next sclk edge is leading when an even number of edges has been produced so far.
   assign lead    = ~edge_cnt[0];
   // The SETUP tick produces edge 1; XFER ticks produce the rest, then one extra half-period.
   assign do_edge = tick && ((state == S_SETUP) || ((state == S_XFER) && (edge_cnt != LAST_EDGE)));

   // Transfer FSM plus the sclk, shift-register and output registers it drives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         tx_sr    <= '0;
         rx_sr    <= '0;
         edge_cnt <= '0;
         sclk     <= CPOL;
         mosi     <= 1'b0;
         cs_n     <= 1'b1;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.dout <= '0;
`ifdef SPI_MASTER_LOOPBACK_EN
         lb       <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state    <= S_SETUP;
                  cs_n     <= 1'b0;
                  bus.busy <= 1'b1;
                  rx_sr    <= '0;
                  edge_cnt <= '0;
`ifdef SPI_MASTER_LOOPBACK_EN
                  lb       <= loopback;
`endif
                  if (CPHA) begin
                     tx_sr <= bus.din;
                     mosi  <= 1'b0;
                  end else begin
                     tx_sr <= shift_out(bus.din);
                     mosi  <= first_bit(bus.din);
                  end
               end
            end
            S_SETUP: begin
               if (tick) begin
                  state <= S_XFER;
               end
            end
            S_XFER: begin
               if (tick && (edge_cnt == LAST_EDGE)) begin
                  state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (tick) begin
                  state    <= S_IDLE;
                  cs_n     <= 1'b1;
                  mosi     <= 1'b0;
                  bus.busy <= 1'b0;
                  bus.dout <= rx_sr;
                  bus.done <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         if (do_edge) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + EW'(1);
            if (lead ^ CPHA) begin
               rx_sr <= shift_in(rx_sr, rx_bit);
            end
            // CPHA=1 advances on leading edges; CPHA=0 on trailing edges except the final one.
            if (CPHA ? lead : (!lead && (edge_cnt != PENULT))) begin
               mosi  <= first_bit(tx_sr);
               tx_sr <= shift_out(tx_sr);
            end
         end
      end
   end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: self-checking bench for spi_master_ctrl.
// Instance 0: mode 0, MSB first, CLK_DIV=2. Instance 1: mode 3, LSB first, CLK_DIV=1.
// A behavioural SPI slave per instance drives miso and captures mosi.
module tb_spi_master_ctrl;
   localparam bit [1:0] TB_CPOL = 2'b10;
   localparam bit [1:0] TB_CPHA = 2'b10;
   localparam bit [1:0] TB_MSB  = 2'b01;
`ifdef SPI_MASTER_LOOPBACK_EN
   localparam bit HAS_LB = 1'b1;
`else
   localparam bit HAS_LB = 1'b0;
`endif

   typedef struct {
      int          inst;
      logic [11:0] din;
      logic [11:0] sw;
      bit          tie;
      logic [11:0] exp;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [1:0]  start_v;
   logic [11:0] din_v [2];
   logic [1:0]  tie_v;
   logic [1:0]  lb_v;
   logic [1:0]  slv_miso;
   wire  [1:0]  busy_v, done_v, sclk_w, mosi_w, cs_w, miso_w;
   wire  [11:0] dout_v [2];

   int vec, errs;
   int w_cyc, w_cshi, w_busylo, w_edge1;
   bit w_ok;
   logic w_mosi1;

   logic [11:0] s_word [2];
   logic [11:0] s_cap [2];
   int          s_edges [2], s_bitk [2], s_capk [2], done_cnt [2];
   logic [1:0]  prev_cs, prev_sclk;

   spi_master_ctrl_if #(.BITS(12)) ifa ();
   spi_master_ctrl_if #(.BITS(12)) ifb ();

   assign ifa.start = start_v[0];
   assign ifa.din   = din_v[0];
   assign ifb.start = start_v[1];
   assign ifb.din   = din_v[1];
   assign busy_v    = {ifb.busy, ifa.busy};
   assign done_v    = {ifb.done, ifa.done};
   assign dout_v[0] = ifa.dout;
   assign dout_v[1] = ifb.dout;
   assign miso_w[0] = tie_v[0] ? mosi_w[0] : slv_miso[0];
   assign miso_w[1] = tie_v[1] ? mosi_w[1] : slv_miso[1];

   spi_master_ctrl #(.BITS(12), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa), .miso(miso_w[0]),
`ifdef SPI_MASTER_LOOPBACK_EN
      .loopback(lb_v[0]),
`endif
      .sclk(sclk_w[0]), .mosi(mosi_w[0]), .cs_n(cs_w[0]));

   spi_master_ctrl #(.BITS(12), .CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb), .miso(miso_w[1]),
`ifdef SPI_MASTER_LOOPBACK_EN
      .loopback(lb_v[1]),
`endif
      .sclk(sclk_w[1]), .mosi(mosi_w[1]), .cs_n(cs_w[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int div_of(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   // Position of the k-th transmitted bit inside the word.
   function automatic int pos(input int i, input int k);
      return TB_MSB[i] ? 11 - k : k;
   endfunction

   // Behavioural SPI slave: presents s_word, captures mosi, counts sclk edges.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (prev_cs[i] && !cs_w[i]) begin
            s_edges[i] = 0;
            s_capk[i]  = 0;
            s_cap[i]   = '0;
            if (!TB_CPHA[i]) begin
               slv_miso[i] = s_word[i][pos(i, 0)];
               s_bitk[i]   = 1;
            end else begin
               slv_miso[i] = 1'b0;
               s_bitk[i]   = 0;
            end
         end else if (!cs_w[i] && (sclk_w[i] != prev_sclk[i])) begin
            s_edges[i] = s_edges[i] + 1;
            if (((s_edges[i] % 2) == 1) ^ TB_CPHA[i]) begin
               if (s_capk[i] < 12) s_cap[i][pos(i, s_capk[i])] = mosi_w[i];
               s_capk[i] = s_capk[i] + 1;
            end else if (s_bitk[i] < 12) begin
               slv_miso[i] = s_word[i][pos(i, s_bitk[i])];
               s_bitk[i]   = s_bitk[i] + 1;
            end
         end
         if (done_v[i]) done_cnt[i] = done_cnt[i] + 1;
         prev_cs[i]   = cs_w[i];
         prev_sclk[i] = sclk_w[i];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Count cycles after the acceptance edge until done (bounded), recording window properties.
   task automatic wait_done(input int i);
      w_cyc = 0; w_cshi = 0; w_busylo = 0; w_ok = 1'b0; w_edge1 = 0; w_mosi1 = 1'b0;
      while (w_cyc < 200 && !w_ok) begin
         @(negedge clk);
         w_cyc++;
         if (w_cyc == 1) w_mosi1 = mosi_w[i];
         if (w_edge1 == 0 && sclk_w[i] != TB_CPOL[i]) w_edge1 = w_cyc;
         if (done_v[i]) begin
            w_ok = 1'b1;
         end else begin
            if (cs_w[i]) w_cshi++;
            if (!busy_v[i]) w_busylo++;
         end
      end
   endtask

   task automatic start_xfer(input int i, input logic [11:0] d, input logic [11:0] sw, input bit tie, input bit lb);
      @(negedge clk);
      tie_v[i] = tie; lb_v[i] = lb; s_word[i] = sw; din_v[i] = d; start_v[i] = 1'b1;
      @(posedge clk);
      #1;
      start_v[i] = 1'b0;
      din_v[i]   = 12'($urandom);
   endtask

   task automatic xfer(input int i, input logic [11:0] d, input logic [11:0] sw, input bit tie, input bit lb, input logic [11:0] exp);
      logic expm;
      expm = TB_CPHA[i] ? 1'b0 : d[pos(i, 0)];
      start_xfer(i, d, sw, tie, lb);
      wait_done(i);
      chk("done_seen", 32'(w_ok), 32'd1);
      chk("done_cycle", w_cyc, 1 + (2 * 12 + 2) * div_of(i));
      chk("first_sclk_edge", w_edge1, 1 + div_of(i));
      chk("mosi_in_setup", 32'(w_mosi1), 32'(expm));
      chk("cs_busy_window", w_cshi + w_busylo, 0);
      chk("sclk_edges", s_edges[i], 24);
      chk("mosi_word", 32'(s_cap[i]), 32'(d));
      chk("dout", 32'(dout_v[i]), 32'(exp));
      chk("idle_pins", {cs_w[i], sclk_w[i], mosi_w[i], busy_v[i]}, {1'b1, TB_CPOL[i], 1'b0, 1'b0});
   endtask

   initial begin
      vec_t        tbl [7];
      logic [11:0] d, sw;
      bit          tie, lb;
      int          i, d0, d1, cyc;

      vec = 0; errs = 0;
      rst = 1'b1; start_v = '0; tie_v = '0; lb_v = '0; slv_miso = '0;
      din_v[0] = '0; din_v[1] = '0; s_word[0] = '0; s_word[1] = '0;
      s_cap[0] = '0; s_cap[1] = '0; s_edges[0] = 0; s_edges[1] = 0;
      s_bitk[0] = 0; s_bitk[1] = 0; s_capk[0] = 0; s_capk[1] = 0;
      done_cnt[0] = 0; done_cnt[1] = 0;
      prev_cs = 2'b11; prev_sclk = TB_CPOL;

      tbl[0] = '{0, 12'hA5C, 12'h000, 1'b1, 12'hA5C};
      tbl[1] = '{1, 12'h0F0, 12'h3C1, 1'b0, 12'h3C1};
      tbl[2] = '{0, 12'h000, 12'hFFF, 1'b0, 12'hFFF};
      tbl[3] = '{0, 12'hFFF, 12'h000, 1'b0, 12'h000};
      tbl[4] = '{1, 12'h801, 12'h001, 1'b0, 12'h001};
      tbl[5] = '{1, 12'h555, 12'h000, 1'b1, 12'h555};
      tbl[6] = '{0, 12'h123, 12'h800, 1'b0, 12'h800};

      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("reset_state", {cs_w[k], sclk_w[k], mosi_w[k], busy_v[k], done_v[k], dout_v[k]},
             {1'b1, TB_CPOL[k], 1'b0, 1'b0, 1'b0, 12'h000});
      end
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 7; k++) begin
         xfer(tbl[k].inst, tbl[k].din, tbl[k].sw, tbl[k].tie, 1'b0, tbl[k].exp);
      end

      for (int k = 0; k < 16; k++) begin
         i   = k % 2;
         d   = 12'($urandom);
         sw  = 12'($urandom);
         tie = 1'($urandom_range(0, 1));
         lb  = HAS_LB ? 1'($urandom_range(0, 1)) : 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         xfer(i, d, sw, tie, lb, (tie || lb) ? d : sw);
      end

`ifdef SPI_MASTER_LOOPBACK_EN
      xfer(0, 12'h5A5, 12'h000, 1'b0, 1'b1, 12'h5A5);
      lb_v = '0;
`endif

      // Back-to-back: start held high, din switched right after the first acceptance.
      @(negedge clk);
      tie_v[0] = 1'b1; din_v[0] = 12'h001; start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      din_v[0] = 12'hFFF;
      wait_done(0);
      chk("b2b_first_done", w_cyc, 53);
      chk("b2b_first_dout", 32'(dout_v[0]), 32'h001);
      chk("b2b_cs_high_at_done", 32'(cs_w[0]), 32'd1);
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      wait_done(0);
      chk("b2b_done_spacing", w_cyc, 53);
      chk("b2b_cs_low_window", w_cshi, 0);
      chk("b2b_second_dout", 32'(dout_v[0]), 32'hFFF);

      // start pulsed at cycle 10 of an active transfer must be ignored.
      start_xfer(0, 12'h3A7, 12'h000, 1'b1, 1'b0);
      d0 = done_cnt[0];
      repeat (9) @(negedge clk);
      start_v[0] = 1'b1; din_v[0] = 12'h111;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_done(0);
      cyc = 10 + w_cyc;
      chk("ignored_start_done", cyc, 53);
      repeat (60) @(negedge clk);
      chk("ignored_start_single_done", done_cnt[0] - d0, 1);
      chk("ignored_start_dout", 32'(dout_v[0]), 32'h3A7);

      // Reset at cycle 20 of a transfer: outputs return to reset values at once, no done later.
      start_xfer(0, 12'h6B3, 12'h000, 1'b1, 1'b0);
      repeat (19) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("mid_reset_outputs", {cs_w[k], sclk_w[k], mosi_w[k], busy_v[k], done_v[k], dout_v[k]},
             {1'b1, TB_CPOL[k], 1'b0, 1'b0, 1'b0, 12'h000});
      end
      @(negedge clk);
      rst = 1'b0;
      d0 = done_cnt[0];
      d1 = done_cnt[1];
      repeat (80) @(negedge clk);
      chk("no_done_after_reset", (done_cnt[0] - d0) + (done_cnt[1] - d1), 0);
      chk("idle_after_reset", {cs_w[0], busy_v[0], dout_v[0]}, {1'b1, 1'b0, 12'h000});

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
